rv32i_multicycle_ctrl: RTL and testbench

Main control FSM for the RV32I multicycle core. It steps each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, the ALU operation class and the write strobes for PC, IR, register file and memory. It waits on a ready handshake from the shared instruction/data memory port. The ALU output register is free-running (loads every cycle), so the ALU inputs must be held stable in any state that consumes the previous ALUOut.

---
 rtl/rv32i_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// Main control FSM for the RV32I multicycle core: fetch/decode/execute/memory/writeback sequencing.
// Optional illegal-instruction trapping is enabled by defining RV32I_CTRL_TRAP_EN.
module rv32i_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] state,
    output logic       illegal
);
    // Memory handshake: mem_req is held until the cycle mem_ready is seen high,
    // which completes the request; no strobe fires in a cycle without mem_ready.

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t cur, nxt;
    logic   taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_FETCH;
        else      cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt        = cur;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        imm_src    = 3'b000;
        illegal    = 1'b0;
        taken      = 1'b0;

        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase

        // Reset overrides every output combinationally so they clear with rst, not the next edge.
        if (rst) begin
            case (opcode)
                OP_STORE:          imm_src = 3'b001;
                OP_BRANCH:         imm_src = 3'b010;
                OP_JAL:            imm_src = 3'b011;
                OP_LUI, OP_AUIPC:  imm_src = 3'b100;
                default:           imm_src = 3'b000;
            endcase

            case (cur)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxt      = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    case (opcode)
                        OP_LOAD, OP_STORE: nxt = S_MEMADR;
                        OP_R:              nxt = S_EXECR;
                        OP_I:              nxt = S_EXECI;
                        OP_BRANCH: begin
                            nxt = S_BRANCH;
`ifdef RV32I_CTRL_TRAP_EN
                            if (funct3[2:1] == 2'b01) nxt = S_TRAP;
`endif
                        end
                        OP_JAL:            nxt = S_JAL;
                        OP_JALR:           nxt = S_JALR;
                        OP_LUI:            nxt = S_LUI;
                        OP_AUIPC:          nxt = S_ALUWB;
`ifdef RV32I_CTRL_TRAP_EN
                        default:           nxt = S_TRAP;
`else
                        default:           nxt = S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    nxt       = opcode[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD, S_MEMWRITE: begin
                    // ALU selects match MEMADR so the free-running ALUOut keeps the address.
                    mem_req   = 1'b1;
                    mem_write = (cur == S_MEMWRITE);
                    adr_src   = 1'b1;
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    if (mem_ready) nxt = (cur == S_MEMWRITE) ? S_FETCH : S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    nxt        = S_FETCH;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                    nxt       = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                    nxt       = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    nxt       = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_write  = taken;
                    nxt       = S_FETCH;
                end
                S_JAL: begin
                    // PC takes the target from ALUOut while the ALU forms OldPC+4 for the link.
                    pc_write  = 1'b1;
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    nxt       = S_ALUWB;
                end
                S_JALR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    nxt       = S_JAL;
                end
                S_LUI: begin
                    result_src = 2'b11;
                    reg_write  = 1'b1;
                    nxt        = S_FETCH;
                end
                S_TRAP: begin
                    nxt = S_TRAP;
`ifdef RV32I_CTRL_TRAP_EN
                    illegal = 1'b1;
`endif
                end
                default: nxt = S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl: per-instruction state/output traces
// compared against a class-level sequence model; honours RV32I_CTRL_TRAP_EN.
module tb_rv32i_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero, lt, ltu, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic [3:0] state;
    logic       illegal;

    int n_vec = 0;
    int n_miss = 0;

    logic [21:0] obs_q[$];
    logic [21:0] exp_q[$];
    logic        rdy_q[$];

    rv32i_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt),
        .ltu(ltu), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] observe();
        return {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, illegal, imm_src};
    endfunction

    // Expected control word for each architectural step.
    // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,a,b,op,res}
    function automatic logic [13:0] exp_outs(input logic [3:0] s, input logic r, input logic tk);
        case (s)
            4'd0:  return {1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
            4'd1:  return {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00};
            4'd2:  return {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00};
            4'd3:  return {6'b101000, 2'b10, 2'b01, 2'b00, 2'b00};
            4'd5:  return {6'b111000, 2'b10, 2'b01, 2'b00, 2'b00};
            4'd4:  return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b01};
            4'd6:  return {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00};
            4'd7:  return {6'b000000, 2'b10, 2'b01, 2'b10, 2'b00};
            4'd8:  return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
            4'd9:  return {4'b0000, tk, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00};
            4'd10: return {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00};
            4'd11: return {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00};
            4'd12: return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b11};
            default: return 14'd0;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    // Branch outcome from the operand values themselves.
    function automatic logic exp_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: the step list for each instruction class, with memory steps repeated per wait.
    function automatic void build_exp(input logic [6:0] op, input logic [2:0] f3, input logic tk, input int max_cyc);
        logic [3:0] base[$];
        int idx = 0;
        logic r;
        exp_q.delete();
        case (op)
            7'b0000011: base = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            7'b0100011: base = '{4'd0, 4'd1, 4'd2, 4'd5};
            7'b0110011: base = '{4'd0, 4'd1, 4'd6, 4'd8};
            7'b0010011: base = '{4'd0, 4'd1, 4'd7, 4'd8};
`ifdef RV32I_CTRL_TRAP_EN
            7'b1100011: base = (f3[2:1] == 2'b01) ? '{4'd0, 4'd1, 4'd13} : '{4'd0, 4'd1, 4'd9};
`else
            7'b1100011: base = '{4'd0, 4'd1, 4'd9};
`endif
            7'b1101111: base = '{4'd0, 4'd1, 4'd10, 4'd8};
            7'b1100111: base = '{4'd0, 4'd1, 4'd11, 4'd10, 4'd8};
            7'b0110111: base = '{4'd0, 4'd1, 4'd12};
            7'b0010111: base = '{4'd0, 4'd1, 4'd8};
`ifdef RV32I_CTRL_TRAP_EN
            default:    base = '{4'd0, 4'd1, 4'd13};
`else
            default:    base = '{4'd0, 4'd1};
`endif
        endcase
        foreach (base[k]) begin
            do begin
                r = (idx < rdy_q.size()) ? rdy_q[idx] : 1'b1;
                exp_q.push_back({base[k], exp_outs(base[k], r, tk), base[k] == 4'd13, exp_imm(op)});
                idx++;
            end while ((base[k] == 4'd0 || base[k] == 4'd3 || base[k] == 4'd5 || base[k] == 4'd13)
                       && (!r || base[k] == 4'd13) && exp_q.size() < max_cyc);
        end
    endfunction

    // Driver: called just after a falling edge with the DUT in FETCH; records one
    // instruction's trace until FETCH is re-entered or max_cyc cycles elapse.
    // mode 0: mem_ready=1, 1: random, 2: low on cycles 3 and 4.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input int mode, input int max_cyc);
        logic [3:0] prev = 4'd0;
        opcode = op;
        funct3 = f3;
        zero   = (a - b) == 32'd0;
        lt     = $signed(a) < $signed(b);
        ltu    = a < b;
        obs_q.delete();
        rdy_q.delete();
        for (int c = 0; c < max_cyc; c++) begin
            case (mode)
                1:       mem_ready = ($urandom_range(0, 2) != 0);
                2:       mem_ready = !(c == 3 || c == 4);
                default: mem_ready = 1'b1;
            endcase
            #1;
            if (c > 0 && state == 4'd0 && prev != 4'd0) break;
            prev = state;
            obs_q.push_back(observe());
            rdy_q.push_back(mem_ready);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        opcode = 7'b0100011;
        funct3 = 3'b000;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (observe() !== 22'd0) begin
            n_miss++;
            $display("FAIL reset_outputs got %h want %h", observe(), 22'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({state, mem_req, adr_src} !== {4'd0, 1'b1, 1'b0}) begin
            n_miss++;
            $display("FAIL reset_release state/mem_req/adr_src got %h/%b/%b want 0/1/0", state, mem_req, adr_src);
        end
    endtask

    task automatic test_directed();
        logic [6:0]  ops[6] = '{7'b0110011, 7'b0000011, 7'b1100011, 7'b1100011, 7'b1100111, 7'b0000000};
        logic [2:0]  f3s[6] = '{3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
        int          mds[6] = '{0, 2, 0, 0, 0, 0};
        logic [31:0] a;
        for (int t = 0; t < 6; t++) begin
            a = $urandom;
            // Both branches see equal operands (zero=1); the illegal opcode is checked last.
`ifdef RV32I_CTRL_TRAP_EN
            if (t == 5) break;
`endif
            run_instr(ops[t], f3s[t], a, a, mds[t], 40);
            build_exp(ops[t], f3s[t], exp_taken(f3s[t], a, a), 40);
            n_vec++;
            if (obs_q.size() != exp_q.size()) begin
                n_miss++;
                $display("FAIL directed%0d trace_length got %0d want %0d", t, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_miss++;
                    $display("FAIL directed%0d cycle%0d got %h want %h", t, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [6:0]  legal[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int t = 0; t < 60; t++) begin
            op = legal[$urandom_range(0, 8)];
`ifndef RV32I_CTRL_TRAP_EN
            if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127)) & 7'b1111000;
`endif
            f3 = 3'($urandom_range(0, 7));
`ifdef RV32I_CTRL_TRAP_EN
            if (op == 7'b1100011 && f3[2:1] == 2'b01) f3 = 3'b000;
`endif
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(op, f3, a, b, 1, 60);
            build_exp(op, f3, exp_taken(f3, a, b), 60);
            n_vec++;
            if (obs_q.size() != exp_q.size()) begin
                n_miss++;
                $display("FAIL random%0d op=%b trace_length got %0d want %0d", t, op, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_miss++;
                    $display("FAIL random%0d op=%b cycle%0d got %h want %h", t, op, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic hit = 1'b0;
        opcode = 7'b0000011;
        funct3 = 3'b010;
        for (int c = 0; c < 12; c++) begin
            mem_ready = 1'b1;
            #1;
            if (state == 4'd3) begin
                mem_ready = 1'b0;
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!hit) begin
            n_miss++;
            $display("FAIL async_reset reach_memread got state %0d want 3", state);
        end
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (observe() !== 22'd0) begin
            n_miss++;
            $display("FAIL async_reset outputs got %h want %h", observe(), 22'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_vec++;
        if ({state, mem_req, adr_src} !== {4'd0, 1'b1, 1'b0}) begin
            n_miss++;
            $display("FAIL async_reset release got %h/%b/%b want 0/1/0", state, mem_req, adr_src);
        end
    endtask

    task automatic test_illegal();
`ifdef RV32I_CTRL_TRAP_EN
        run_instr(7'b0000000, 3'b000, 32'd0, 32'd1, 1, 14);
        build_exp(7'b0000000, 3'b000, 1'b0, 14);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_miss++;
            $display("FAIL trap trace_length got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL trap cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({state, illegal} !== {4'd0, 1'b0}) begin
            n_miss++;
            $display("FAIL trap_clear got state %0d illegal %b want 0 0", state, illegal);
        end
        @(negedge clk);
        rst = 1'b1;
`else
        run_instr(7'b0000000, 3'b000, 32'd0, 32'd1, 0, 40);
        build_exp(7'b0000000, 3'b000, 1'b0, 40);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_miss++;
            $display("FAIL nop trace_length got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_miss++;
                $display("FAIL nop cycle%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        #1;
        n_vec++;
        if ({state, illegal} !== {4'd0, 1'b0}) begin
            n_miss++;
            $display("FAIL nop_return got state %0d illegal %b want 0 0", state, illegal);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        @(negedge clk);
        test_async_reset();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
